// File: rtl/sync_arith_unit29.sv
// sync_arith_unit29: registered shift / signed compare / divide / sign-magnitude-to-two's-complement unit
module sync_arith_unit29 #(
    parameter int M = 32
) (
    input  logic         clk,
    input  logic         i_reset,
    input  logic [M-1:0] iarg_A,
    input  logic [M-1:0] iarg_B,
    input  logic [3:0]   iop,
    output logic [M-1:0] o_result,
    output logic [3:0]   o_status
);
    localparam logic [M-1:0] MW = M;
    logic [2*M-1:0] ext;
    logic [M-1:0]   zm;
    logic [M-1:0]   res;
    logic           big;
    logic           b_zero;
    logic           err;
    logic           ovf;
    // Upper half of the double-width shift holds every bit pushed past the MSB
    assign ext    = {{M{1'b0}}, iarg_A} << iarg_B;
    assign big    = iarg_B >= MW;
    assign b_zero = iarg_B == '0;
    assign zm     = iarg_A[M-1] ? -{1'b0, iarg_A[M-2:0]} : iarg_A;
    always_comb begin
        res = iop == 4'd0 ? (big ? '0 : ext[M-1:0]) :
              iop == 4'd1 ? {{(M-1){1'b0}}, $signed(iarg_A) > $signed(iarg_B)} :
              iop == 4'd2 ? (b_zero ? '0 : iarg_A / iarg_B) :
              iop == 4'd3 ? zm : '0;
        err = (iop == 4'd2 && b_zero) || iop > 4'd3;
        ovf = iop == 4'd0 && !big && |ext[2*M-1:M];
    end
    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            o_result <= '0;
            o_status <= '0;
        end else begin
            o_result <= res;
            o_status <= {err, ovf, res[M-1], res == '0};
        end
    end
endmodule

// File: tb/tb_sync_arith_unit29.sv
// tb_sync_arith_unit29: directed literal checks plus randomized back-to-back traffic
// compared every cycle against a behavioural model.
module tb_sync_arith_unit29;
    logic        clk = 0;
    logic        i_reset = 1;
    logic [31:0] iarg_A = 0;
    logic [31:0] iarg_B = 0;
    logic [3:0]  iop = 0;
    logic [31:0] o_result;
    logic [3:0]  o_status;
    logic [35:0] exp_q;
    logic        armed = 0;
    int          total = 0;
    int          bad = 0;

    sync_arith_unit29 #(.M(32)) dut (
        .clk(clk), .i_reset(i_reset), .iarg_A(iarg_A), .iarg_B(iarg_B),
        .iop(iop), .o_result(o_result), .o_status(o_status)
    );

    always #5 clk = ~clk;

    // Returns {ERR, OVF, NEG, ZERO, result}
    function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
        logic [31:0] r = 0;
        logic err = 0, ovf = 0;
        case (op)
            4'd0: begin
                r   = b < 32 ? a << b : 32'd0;
                ovf = b < 32 && ((r >> b) != a);
            end
            4'd1: r = (int'(a) > int'(b)) ? 32'd1 : 32'd0;
            4'd2: if (b == 0) err = 1; else r = a / b;
            4'd3: r = a[31] ? 32'd0 - (a & 32'h7FFF_FFFF) : a;
            default: err = 1;
        endcase
        return {err, ovf, r[31], r == 0, r};
    endfunction

    always @(posedge clk or negedge i_reset)
        exp_q = !i_reset ? 36'd0 : model(iarg_A, iarg_B, iop);

    always @(negedge clk) if (armed) begin
        total++;
        if ({o_status, o_result} !== exp_q) begin
            bad++;
            $display("FAIL cycle t=%0t: got result=%h status=%b, want result=%h status=%b",
                     $time, o_result, o_status, exp_q[31:0], exp_q[35:32]);
        end
    end

    task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] b,
                       input logic [3:0] op, input logic [31:0] er, input logic [3:0] es);
        logic [35:0] m;
        m = model(a, b, op);
        total++;
        if (m !== {es, er}) begin
            bad++;
            $display("FAIL model %s: got %h/%b want %h/%b", nm, m[31:0], m[35:32], er, es);
        end
        @(negedge clk);
        iarg_A = a; iarg_B = b; iop = op;
        @(posedge clk);
        #1;
        total++;
        if (o_result !== er || o_status !== es) begin
            bad++;
            $display("FAIL %s: got result=%h status=%b want result=%h status=%b", nm, o_result, o_status, er, es);
        end
    endtask

    initial begin
        logic [3:0]  op;
        logic [31:0] b;
        #1 i_reset = 0;
        armed = 1;
        #1;
        total++;
        if (o_result !== 0 || o_status !== 0) begin
            bad++;
            $display("FAIL reset: got %h/%b want 0/0000", o_result, o_status);
        end
        repeat (2) @(negedge clk);
        #2 i_reset = 1;
        chk("shl4",   32'hFFFF0000, 4,  4'd0, 32'hFFF00000, 4'b0110);
        chk("shl16",  32'h12345678, 16, 4'd0, 32'h56780000, 4'b0100);
        chk("shl40",  32'h1,        40, 4'd0, 32'h0,        4'b0001);
        chk("shl0",   32'h80000000, 0,  4'd0, 32'h80000000, 4'b0010);
        chk("shl31",  32'h3,        31, 4'd0, 32'h80000000, 4'b0110);
        chk("cmp_gt", 10, 5,  4'd1, 1, 4'b0000);
        chk("cmp_lt", 20, 25, 4'd1, 0, 4'b0001);
        chk("cmp_eq", 15, 15, 4'd1, 0, 4'b0001);
        chk("cmp_neg", 32'hFFFFFFFF, 1, 4'd1, 0, 4'b0001);
        chk("cmp_sgn", 1, 32'h80000000, 4'd1, 1, 4'b0000);
        chk("div1", 100, 10, 4'd2, 32'hA, 4'b0000);
        chk("div2", 50,  5,  4'd2, 32'hA, 4'b0000);
        chk("div3", 200, 20, 4'd2, 32'hA, 4'b0000);
        chk("div0", 7,   0,  4'd2, 0,     4'b1001);
        chk("div_big", 32'hFFFFFFFF, 3, 4'd2, 32'h55555555, 4'b0000);
        chk("zm1",  32'h80000001, 0, 4'd3, 32'hFFFFFFFF, 4'b0010);
        chk("zm2",  32'h7FFFFFFF, 0, 4'd3, 32'h7FFFFFFF, 4'b0000);
        chk("zm3",  32'h80012345, 0, 4'd3, 32'hFFFEDCBB, 4'b0010);
        chk("zm0",  32'h80000000, 0, 4'd3, 0,            4'b0001);
        chk("ill",  32'h1234, 5, 4'b1010, 0, 4'b1001);
        chk("ill15", 0, 0, 4'b1111, 0, 4'b1001);
        // Mid-cycle async reset, then mid-cycle release
        chk("pre_rst", 32'hFFFF0000, 4, 4'd0, 32'hFFF00000, 4'b0110);
        #2 i_reset = 0;
        #1;
        total++;
        if (o_result !== 0 || o_status !== 0) begin
            bad++;
            $display("FAIL async_reset: got %h/%b want 0/0000", o_result, o_status);
        end
        #1 i_reset = 1;
        chk("post_rst", 100, 10, 4'd2, 32'hA, 4'b0000);
        // Randomized back-to-back traffic, opcode changes every cycle
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            op = ($urandom % 5 == 0) ? 4'($urandom_range(4, 15)) : 4'($urandom_range(0, 3));
            b  = (op == 4'd0) ? 32'($urandom_range(0, 40)) :
                 ($urandom % 8 == 0) ? 32'd0 :
                 ($urandom % 3 == 0) ? 32'($urandom_range(1, 300)) : 32'($urandom);
            iarg_A = ($urandom % 6 == 0) ? 32'($urandom_range(0, 300)) : 32'($urandom);
            iarg_B = b;
            iop = op;
        end
        @(negedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
